// File: rtl/eth_traffic_seq_pkg.sv
// Shared constants, state encoding and helpers for the ethernet traffic port sequencer.
// Register map defaults match the traffic controller CSR block.
package eth_traffic_seq_pkg;

    localparam logic [15:0] DEF_ADDR_NUM_PKT = 16'h1000;
    localparam logic [15:0] DEF_ADDR_START   = 16'h1004;
    localparam logic [15:0] DEF_ADDR_STATUS  = 16'h1008;
    localparam logic [15:0] DEF_ADDR_ERR_CNT = 16'h100C;

    localparam int STATUS_DONE_BIT = 0;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SCAN    = 3'd1,
        S_WR_CNT  = 3'd2,
        S_WR_GO   = 3'd3,
        S_GAP     = 3'd4,
        S_RD_STAT = 3'd5,
        S_RD_ERR  = 3'd6,
        S_FIN     = 3'd7
    } seq_state_e;

    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } lowest_bit_t;

    // Lowest set bit wins, so channels are visited in ascending order.
    function automatic lowest_bit_t find_lowest(input logic [15:0] v);
        lowest_bit_t r;
        r.found = 1'b0;
        r.idx   = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) begin
                r.found = 1'b1;
                r.idx   = 4'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/eth_traffic_port_sequencer_if.sv
// AVMM CSR bus between the sequencer (master) and the traffic controller CSR port (slave).
interface eth_traffic_port_sequencer_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] addr;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;
    logic              waitrequest;

    modport master (
        output addr, read, write, writedata,
        input  readdata, waitrequest
    );

    modport slave (
        input  addr, read, write, writedata,
        output readdata, waitrequest
    );
endinterface

// File: rtl/eth_seq_avmm_master.sv
// Single-outstanding AVMM command holder: latches a request, holds it through waitrequest,
// then drops the command and returns a one-cycle ack with the captured read data.
module eth_seq_avmm_master #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ack,
    output logic [DATA_W-1:0] rdata,
    eth_traffic_port_sequencer_if.master avmm
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            avmm.read      <= 1'b0;
            avmm.write     <= 1'b0;
            avmm.addr      <= '0;
            avmm.writedata <= '0;
            ack            <= 1'b0;
            rdata          <= '0;
        end else begin
            ack <= 1'b0;
            if (avmm.read || avmm.write) begin
                // Zero-latency read: data is valid in the completing cycle.
                if (!avmm.waitrequest) begin
                    avmm.read  <= 1'b0;
                    avmm.write <= 1'b0;
                    ack        <= 1'b1;
                    rdata      <= avmm.readdata;
                end
            end else if (req) begin
                avmm.addr      <= addr;
                avmm.writedata <= wdata;
                avmm.read      <= ~we;
                avmm.write     <= we;
            end
        end
    end

endmodule

// File: rtl/eth_traffic_port_sequencer.sv
// Loopback test sequencer: walks the selected channels in ascending order over the AVMM CSR
// port and reports per-channel pass / fail / timeout bitmasks.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   IDLE      | waiting for i_start
//   SCAN      | pick lowest remaining channel, or finish if none left
//   WR_CNT    | write packet count
//   WR_GO     | write start, clear poll counter
//   GAP       | idle POLL_GAP cycles between status polls
//   RD_STAT   | read status, check done bit and poll limit
//   RD_ERR    | read error count, record pass or fail
//   FIN       | pulse done, drop busy
module eth_traffic_port_sequencer
    import eth_traffic_seq_pkg::*;
#(
    parameter int          NUM_CH       = 16,
    parameter int          AVMM_ADDR_W  = 16,
    parameter int          AVMM_DATA_W  = 32,
    parameter logic [15:0] ADDR_NUM_PKT = DEF_ADDR_NUM_PKT,
    parameter logic [15:0] ADDR_START   = DEF_ADDR_START,
    parameter logic [15:0] ADDR_STATUS  = DEF_ADDR_STATUS,
    parameter logic [15:0] ADDR_ERR_CNT = DEF_ADDR_ERR_CNT,
    parameter int          POLL_GAP     = 64,
    parameter int          POLL_LIMIT   = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [NUM_CH-1:0] i_port_mask,
    input  logic [31:0]       i_pkt_count,
    eth_traffic_port_sequencer_if.master avmm,
    output logic [3:0]        o_csr_port_sel,
    output logic              o_busy,
    output logic              o_done,
    output logic [NUM_CH-1:0] o_pass_mask,
    output logic [NUM_CH-1:0] o_fail_mask,
    output logic [NUM_CH-1:0] o_timeout_mask
);

    localparam int GAP_W  = $clog2(POLL_GAP + 1);
    localparam int POLL_W = $clog2(POLL_LIMIT + 1);

    seq_state_e              state;
    logic [NUM_CH-1:0]       work_mask;
    logic [31:0]             pkt_count;
    logic [GAP_W-1:0]        gap_cnt;
    logic [POLL_W-1:0]       poll_cnt;
    logic                    abort_pend;
    logic                    cmd_pend;

    logic                    cmd_state;
    logic                    cmd_req;
    logic                    cmd_we;
    logic [AVMM_ADDR_W-1:0]  cmd_addr;
    logic [AVMM_DATA_W-1:0]  cmd_wdata;
    logic                    cmd_ack;
    logic [AVMM_DATA_W-1:0]  cmd_rdata;
    lowest_bit_t             next_ch;
    logic [NUM_CH-1:0]       ch_bit;

    assign next_ch = find_lowest(16'(work_mask));
    assign ch_bit  = NUM_CH'(1) << o_csr_port_sel;

    always_comb begin
        cmd_state = 1'b0;
        cmd_we    = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        case (state)
            S_WR_CNT: begin
                cmd_state = 1'b1;
                cmd_we    = 1'b1;
                cmd_addr  = AVMM_ADDR_W'(ADDR_NUM_PKT);
                cmd_wdata = AVMM_DATA_W'(pkt_count);
            end
            S_WR_GO: begin
                cmd_state = 1'b1;
                cmd_we    = 1'b1;
                cmd_addr  = AVMM_ADDR_W'(ADDR_START);
                cmd_wdata = AVMM_DATA_W'(1);
            end
            S_RD_STAT: begin
                cmd_state = 1'b1;
                cmd_addr  = AVMM_ADDR_W'(ADDR_STATUS);
            end
            S_RD_ERR: begin
                cmd_state = 1'b1;
                cmd_addr  = AVMM_ADDR_W'(ADDR_ERR_CNT);
            end
            default: ;
        endcase
    end

    // A pending abort suppresses new commands; an outstanding one is allowed to finish.
    assign cmd_req = cmd_state && !cmd_pend && !abort_pend;

    eth_seq_avmm_master #(
        .ADDR_W (AVMM_ADDR_W),
        .DATA_W (AVMM_DATA_W)
    ) u_avmm_master (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (cmd_req),
        .we    (cmd_we),
        .addr  (cmd_addr),
        .wdata (cmd_wdata),
        .ack   (cmd_ack),
        .rdata (cmd_rdata),
        .avmm  (avmm)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            work_mask      <= '0;
            pkt_count      <= '0;
            gap_cnt        <= '0;
            poll_cnt       <= '0;
            abort_pend     <= 1'b0;
            cmd_pend       <= 1'b0;
            o_csr_port_sel <= '0;
            o_busy         <= 1'b0;
            o_done         <= 1'b0;
            o_pass_mask    <= '0;
            o_fail_mask    <= '0;
            o_timeout_mask <= '0;
        end else begin
            o_done <= 1'b0;
            if (i_abort && state != S_IDLE && state != S_FIN)
                abort_pend <= 1'b1;
            if (cmd_req)
                cmd_pend <= 1'b1;
            if (cmd_ack)
                cmd_pend <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        work_mask      <= i_port_mask;
                        pkt_count      <= i_pkt_count;
                        o_pass_mask    <= '0;
                        o_fail_mask    <= '0;
                        o_timeout_mask <= '0;
                        o_busy         <= 1'b1;
                        state          <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (abort_pend || !next_ch.found) begin
                        state <= S_FIN;
                    end else begin
                        o_csr_port_sel <= next_ch.idx;
                        work_mask      <= work_mask & (work_mask - NUM_CH'(1));
                        state          <= S_WR_CNT;
                    end
                end
                S_WR_CNT: begin
                    if (cmd_ack)
                        state <= abort_pend ? S_FIN : S_WR_GO;
                    else if (abort_pend && !cmd_pend)
                        state <= S_FIN;
                end
                S_WR_GO: begin
                    if (cmd_ack) begin
                        poll_cnt <= '0;
                        gap_cnt  <= GAP_W'(POLL_GAP - 1);
                        state    <= abort_pend ? S_FIN : S_GAP;
                    end else if (abort_pend && !cmd_pend) begin
                        state <= S_FIN;
                    end
                end
                S_GAP: begin
                    if (abort_pend)
                        state <= S_FIN;
                    else if (gap_cnt == '0)
                        state <= S_RD_STAT;
                    else
                        gap_cnt <= gap_cnt - GAP_W'(1);
                end
                S_RD_STAT: begin
                    if (cmd_ack) begin
                        poll_cnt <= poll_cnt + POLL_W'(1);
                        if (abort_pend) begin
                            state <= S_FIN;
                        end else if (cmd_rdata[STATUS_DONE_BIT]) begin
                            state <= S_RD_ERR;
                        end else if (poll_cnt == POLL_W'(POLL_LIMIT - 1)) begin
                            o_timeout_mask <= o_timeout_mask | ch_bit;
                            state          <= S_SCAN;
                        end else begin
                            gap_cnt <= GAP_W'(POLL_GAP - 1);
                            state   <= S_GAP;
                        end
                    end else if (abort_pend && !cmd_pend) begin
                        state <= S_FIN;
                    end
                end
                S_RD_ERR: begin
                    if (cmd_ack) begin
                        if (abort_pend) begin
                            state <= S_FIN;
                        end else begin
                            if (cmd_rdata == '0)
                                o_pass_mask <= o_pass_mask | ch_bit;
                            else
                                o_fail_mask <= o_fail_mask | ch_bit;
                            state <= S_SCAN;
                        end
                    end else if (abort_pend && !cmd_pend) begin
                        state <= S_FIN;
                    end
                end
                S_FIN: begin
                    o_done     <= 1'b1;
                    o_busy     <= 1'b0;
                    abort_pend <= 1'b0;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
